// File: rtl/apb_multi_master_bridge.sv
// APB master bridge: one command at a time from a valid/ready port, run as an
// APB SETUP/ACCESS transfer to the slave decoded from the address. The response
// is held until taken. Unmapped slaves and stuck slaves both complete with rsp_err.
module apb_multi_master_bridge #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int NUM_SLV   = 4,
    parameter int SLV_SHIFT = 12,
    parameter int TIMEOUT   = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0]   NUM_SLV_L = (IDX_W + 1)'(NUM_SLV);
    // Last stalled ACCESS cycle before the transfer is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [IDX_W-1:0]    cmd_idx;
    logic                cmd_hit;
    logic                sel_ready, sel_err;
    logic [DATA_W-1:0]   sel_rdata;
    logic [NUM_SLV-1:0]  psel;

    assign cmd_idx = cmd_addr[SLV_SHIFT +: IDX_W];
    assign cmd_hit = ({1'b0, cmd_idx} < NUM_SLV_L);

    // Route only the addressed slave's response signals and select line.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        psel      = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (IDX_W'(i) == idx_q) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_W +: DATA_W];
                psel[i]   = (state_q == S_SETUP) || (state_q == S_ACCESS);
            end
        end
    end

    // Next-state logic for the transfer sequencer and its captured fields.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                    idx_d    = cmd_idx;
                    rdata_d  = '0;
                    cnt_d    = '0;
                    if (cmd_hit) begin
                        err_d   = 1'b0;
                        state_d = S_SETUP;
                    end else begin
                        // Unmapped slave: answer immediately, never touch the bus.
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // A ready on the final allowed cycle still wins over the timeout.
                if (sel_ready) begin
                    err_d   = sel_err;
                    rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-field registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign PSEL      = psel;
    assign PENABLE   = (state_q == S_ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule
